// File: rtl/jtkcpu_pkg.sv
// Shared constants for the push/pull sequencer: state encoding, postbyte bit map, wide-register mask.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jtkcpu_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DEC  = 3'd1,
        ST_WR   = 3'd2,
        ST_RD   = 3'd3,
        ST_UPD  = 3'd4,
        ST_DONE = 3'd5
    } pshpul_state_t;

    // Postbyte bit positions, 6809 layout
    localparam int CC_BIT = 0;
    localparam int A_BIT  = 1;
    localparam int B_BIT  = 2;
    localparam int DP_BIT = 3;
    localparam int X_BIT  = 4;
    localparam int Y_BIT  = 5;
    localparam int US_BIT = 6;
    localparam int PC_BIT = 7;

    // Registers that occupy two stack bytes (X, Y, U/S, PC)
    localparam logic [7:0] WIDE_MASK = 8'hF0;

endpackage

// File: rtl/jtkcpu_prio8.sv
// 8-bit one-hot priority picker; i_low_first=1 picks the lowest set bit, 0 the highest.
// Latency: combinational.
// Backpressure: none; output follows input.
// Ports: i_vec request mask, i_low_first direction, o_onehot chosen bit (0 when i_vec is 0).
module jtkcpu_prio8 (
    input  logic [7:0] i_vec,
    input  logic       i_low_first,
    output logic [7:0] o_onehot
);

    // The last hit in each loop wins, so the scan order sets the priority.
    always_comb begin
        o_onehot = 8'd0;
        if (i_low_first) begin
            for (int i = 7; i >= 0; i--) begin
                if (i_vec[i]) begin
                    o_onehot    = 8'd0;
                    o_onehot[i] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (i_vec[i]) begin
                    o_onehot    = 8'd0;
                    o_onehot[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/jtkcpu_pshpul.sv
// Push/pull sequencer: walks the postbyte mask and drives register-file selectors, SP strobes and a bus request.
// Latency: 2 cycles per stack byte plus 1 per bus_ack wait; done pulses 2*N+1 cycles after start (1 for empty mask).
// Backpressure: bus_req is held stable in WR/RD until bus_ack; start is ignored while busy.
// Ports: clk/rst (sync, active-high); start/pull/ussel/postbyte request; bus_ack handshake;
//        psh_sel/psh_hilon/psh_ussel/pul_sel/pul_en to register file; bus_req/bus_we to bus; dec_sp/inc_sp; busy/done.
module jtkcpu_pshpul
    import jtkcpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pull,
    input  logic       ussel,
    input  logic [7:0] postbyte,
    input  logic       bus_ack,
    output logic [7:0] psh_sel,
    output logic       psh_hilon,
    output logic       psh_ussel,
    output logic [7:0] pul_sel,
    output logic       pul_en,
    output logic       bus_req,
    output logic       bus_we,
    output logic       dec_sp,
    output logic       inc_sp,
    output logic       busy,
    output logic       done
);

    pshpul_state_t r_state;
    logic [7:0]    r_mask;
    logic          r_pull;
    logic          r_ussel;
    logic          r_hi;

    logic [7:0]    w_pick;
    logic [7:0]    w_mask_clr;
    logic          w_wide;
    logic          w_push_ph;
    logic          w_pull_ph;

    // Pushes go PC first (high bit), pulls go CC first (low bit).
    jtkcpu_prio8 u_prio (
        .i_vec       (r_mask),
        .i_low_first (r_pull),
        .o_onehot    (w_pick)
    );

    assign w_wide     = |(w_pick & WIDE_MASK);
    assign w_mask_clr = r_mask & ~w_pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mask  <= 8'd0;
            r_pull  <= 1'b0;
            r_ussel <= 1'b0;
            r_hi    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mask  <= postbyte;
                        r_pull  <= pull;
                        r_ussel <= ussel;
                        r_hi    <= 1'b0;
                        r_state <= (postbyte == 8'd0) ? ST_DONE : (pull ? ST_RD : ST_DEC);
                    end
                end
                ST_DEC: r_state <= ST_WR;
                ST_WR: begin
                    if (bus_ack) begin
                        // Wide registers take a second byte before the mask bit retires.
                        if (w_wide && !r_hi) begin
                            r_hi    <= 1'b1;
                            r_state <= ST_DEC;
                        end else begin
                            r_mask  <= w_mask_clr;
                            r_hi    <= 1'b0;
                            r_state <= (w_mask_clr == 8'd0) ? ST_DONE : ST_DEC;
                        end
                    end
                end
                ST_RD: begin
                    if (bus_ack) r_state <= ST_UPD;
                end
                ST_UPD: begin
                    if (w_wide && !r_hi) begin
                        r_hi    <= 1'b1;
                        r_state <= ST_RD;
                    end else begin
                        r_mask  <= w_mask_clr;
                        r_hi    <= 1'b0;
                        r_state <= (w_mask_clr == 8'd0) ? ST_DONE : ST_RD;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Every output is a decode of registered state; bus_ack only reaches next-state logic.
    assign w_push_ph = (r_state == ST_DEC) || (r_state == ST_WR);
    assign w_pull_ph = (r_state == ST_RD)  || (r_state == ST_UPD);

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign dec_sp    = (r_state == ST_DEC);
    assign inc_sp    = (r_state == ST_UPD);
    assign pul_en    = (r_state == ST_UPD);
    assign bus_req   = (r_state == ST_WR) || (r_state == ST_RD);
    assign bus_we    = (r_state == ST_WR);
    assign psh_sel   = w_push_ph ? w_pick : 8'd0;
    assign pul_sel   = w_pull_ph ? w_pick : 8'd0;
    // Push writes low byte first; pull reads high byte first.
    assign psh_hilon = (w_push_ph && r_hi) || (w_pull_ph && !r_hi);
    assign psh_ussel = busy && r_ussel;

endmodule

// File: tb/tb_jtkcpu_pshpul.sv
module tb_jtkcpu_pshpul;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pull;
    logic       ussel;
    logic [7:0] postbyte;
    logic       bus_ack;
    logic [7:0] psh_sel;
    logic       psh_hilon;
    logic       psh_ussel;
    logic [7:0] pul_sel;
    logic       pul_en;
    logic       bus_req;
    logic       bus_we;
    logic       dec_sp;
    logic       inc_sp;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    jtkcpu_pshpul dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pull      (pull),
        .ussel     (ussel),
        .postbyte  (postbyte),
        .bus_ack   (bus_ack),
        .psh_sel   (psh_sel),
        .psh_hilon (psh_hilon),
        .psh_ussel (psh_ussel),
        .pul_sel   (pul_sel),
        .pul_en    (pul_en),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .dec_sp    (dec_sp),
        .inc_sp    (inc_sp),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [24:0] outs;
    assign outs = {psh_sel, psh_hilon, psh_ussel, pul_sel, pul_en, bus_req,
                   bus_we, dec_sp, inc_sp, busy, done};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation: reference sequence from the mask, then observe the DUT cycle by cycle.
    task automatic run_op(input logic [7:0] pb, input logic pl, input logic us,
                          input int min_w, input int max_w, input logic poke);
        logic [7:0] exp_sel[$];
        logic       exp_hl[$];
        logic       exp_wide[$];
        logic [7:0] obs_sel[$];
        logic       obs_hl[$];
        int  cyc, done_cyc, n_dec, n_inc, n_pul, n_acc, sum_w, wcnt, tgt, nb;
        bit  we_ok, us_ok, busy_ok, sel_ok;

        // Reference: stack byte order from the 6809 rules.
        for (int k = 0; k < 8; k++) begin
            int b;
            b = pl ? k : 7 - k;
            if (pb[b]) begin
                logic [7:0] oh;
                oh = 8'd0;
                oh[b] = 1'b1;
                if (b >= 4) begin
                    exp_sel.push_back(oh); exp_hl.push_back(pl ? 1'b1 : 1'b0); exp_wide.push_back(1'b1);
                    exp_sel.push_back(oh); exp_hl.push_back(pl ? 1'b0 : 1'b1); exp_wide.push_back(1'b1);
                end else begin
                    exp_sel.push_back(oh); exp_hl.push_back(1'b0); exp_wide.push_back(1'b0);
                end
            end
        end
        nb = exp_sel.size();

        cyc = 1; done_cyc = -1; n_dec = 0; n_inc = 0; n_pul = 0; n_acc = 0;
        sum_w = 0; wcnt = 0; we_ok = 1; us_ok = 1; busy_ok = 1; sel_ok = 1;
        tgt = $urandom_range(max_w, min_w);

        @(negedge clk);
        postbyte = pb; pull = pl; ussel = us; start = 1'b1;
        @(negedge clk);
        start = 1'b0; postbyte = 8'($urandom);

        while (done_cyc < 0 && cyc < 400) begin
            if (done) done_cyc = cyc;
            if (!busy) busy_ok = 0;
            if (psh_ussel !== us) us_ok = 0;
            if (pl && psh_sel !== 8'd0) sel_ok = 0;
            if (!pl && pul_sel !== 8'd0) sel_ok = 0;
            if (dec_sp) begin n_dec++; obs_sel.push_back(psh_sel); obs_hl.push_back(psh_hilon); end
            if (pul_en) begin n_pul++; obs_sel.push_back(pul_sel); obs_hl.push_back(psh_hilon); end
            if (inc_sp) n_inc++;
            if (bus_req) begin
                if (bus_we !== !pl) we_ok = 0;
                if (wcnt == tgt) begin
                    bus_ack = 1'b1; n_acc++; sum_w += tgt; wcnt = 0;
                    tgt = $urandom_range(max_w, min_w);
                end else begin
                    bus_ack = 1'b0; wcnt++;
                end
            end else begin
                bus_ack = 1'($urandom);
            end
            if (poke && cyc == 3) begin
                start = 1'b1; postbyte = ~pb; pull = !pl; ussel = !us;
            end else begin
                start = 1'b0;
            end
            if (done_cyc < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;

        chk("done_cycle", done_cyc, (nb == 0) ? 1 : 2 * nb + 1 + sum_w);
        chk("bus_accesses", n_acc, nb);
        chk("dec_sp_pulses", n_dec, pl ? 0 : nb);
        chk("inc_sp_pulses", n_inc, pl ? nb : 0);
        chk("pul_en_pulses", n_pul, pl ? nb : 0);
        chk("bus_we_dir", {31'd0, we_ok}, 1);
        chk("ussel_fwd", {31'd0, us_ok}, 1);
        chk("busy_held", {31'd0, busy_ok}, 1);
        chk("idle_sel_zero", {31'd0, sel_ok}, 1);
        chk("seq_len", obs_sel.size(), nb);
        for (int i = 0; i < nb && i < obs_sel.size(); i++) begin
            chk($sformatf("seq_sel[%0d]", i), {24'd0, obs_sel[i]}, {24'd0, exp_sel[i]});
            if (exp_wide[i])
                chk($sformatf("seq_hilon[%0d]", i), {31'd0, obs_hl[i]}, {31'd0, exp_hl[i]});
        end

        @(negedge clk);
        bus_ack = 1'b0;
        chk("idle_after_done", {7'd0, outs}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pull = 1'b0; ussel = 1'b0; postbyte = 8'd0; bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("outs_in_reset", {7'd0, outs}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("outs_idle", {7'd0, outs}, 32'd0);

        // Directed cases
        run_op(8'h81, 1'b0, 1'b0, 0, 0, 1'b0);
        run_op(8'h81, 1'b1, 1'b1, 2, 2, 1'b0);
        run_op(8'hFF, 1'b0, 1'b0, 0, 0, 1'b0);
        run_op(8'h00, 1'b0, 1'b1, 0, 0, 1'b0);
        run_op(8'h00, 1'b1, 1'b0, 0, 0, 1'b0);
        run_op(8'h3C, 1'b0, 1'b1, 0, 1, 1'b1);
        run_op(8'hC3, 1'b1, 1'b0, 0, 1, 1'b1);
        run_op(8'hFF, 1'b1, 1'b1, 0, 0, 1'b0);

        // Reset in the middle of a push
        @(negedge clk);
        postbyte = 8'hFF; pull = 1'b0; ussel = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; bus_ack = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("outs_mid_reset", {7'd0, outs}, 32'd0);
        rst = 1'b0; bus_ack = 1'b0;
        @(negedge clk);
        chk("outs_after_reset", {7'd0, outs}, 32'd0);
        run_op(8'h81, 1'b0, 1'b0, 0, 0, 1'b0);

        // Randomised operations
        for (int r = 0; r < 25; r++) begin
            run_op(8'($urandom), 1'($urandom), 1'($urandom), 0, 3, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
